// File: rtl/spi_master.sv
// SPI mode-3 master that alternately polls a gyroscope and an accelerometer,
// sending a read command and returning one data byte per transaction.
module spi_master #(
    parameter int         CLK_DIV    = 2,
    parameter int         GAP_CYCLES = 4,
    parameter logic [5:0] GYRO_ADDR  = 6'h0F,
    parameter logic [5:0] ACCEL_ADDR = 6'h00
) (
    input  logic       clk,
    input  logic       reset,
    output logic       read_ready,
    output logic [7:0] read_data,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO_G,
    output logic       SS_G,
    input  logic       MISO_A,
    output logic       SS_A
);

    localparam logic [2:0] ST_GAP   = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int MAXC = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    logic [2:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_idx, bit_n;
    logic          phase, phase_n;    // 0: SCLK low half, 1: SCLK high half
    logic          target, target_n;  // 0: gyro, 1: accel
    logic [7:0]    shreg;
    logic [7:0]    cmd_n;
    logic          active_n, mosi_n, sample;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CW'(1);
        bit_n    = bit_idx;
        phase_n  = phase;
        target_n = target;
        case (state)
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = ST_SETUP;
                    cnt_n   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt == DIV_LAST) begin
                    state_n = ST_SHIFT;
                    cnt_n   = '0;
                    bit_n   = 4'd0;
                    phase_n = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_n = '0;
                    if (!phase) begin
                        phase_n = 1'b1;
                    end else if (bit_idx == 4'd15) begin
                        state_n = ST_HOLD;
                    end else begin
                        phase_n = 1'b0;
                        bit_n   = bit_idx + 4'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt == DIV_LAST) begin
                    state_n = ST_DONE;
                    cnt_n   = '0;
                end
            end
            ST_DONE: begin
                state_n  = ST_GAP;
                cnt_n    = '0;
                target_n = ~target;
            end
            default: begin
                state_n = ST_GAP;
                cnt_n   = '0;
            end
        endcase
    end

    // MISO is captured on the clock that raises SCLK; only the data half counts
    assign sample = (state == ST_SHIFT) && !phase && (cnt == DIV_LAST) && bit_idx[3];

    // Pin values are decoded from the next state so every output is a flop
    always_comb begin
        active_n = (state_n == ST_SETUP) || (state_n == ST_SHIFT) || (state_n == ST_HOLD);
        cmd_n    = {1'b1, 1'b0, (target_n ? ACCEL_ADDR : GYRO_ADDR)};
        case (state_n)
            ST_SETUP: mosi_n = cmd_n[7];
            ST_SHIFT: mosi_n = bit_n[3] ? 1'b0 : cmd_n[~bit_n[2:0]];
            ST_HOLD:  mosi_n = 1'b0;
            default:  mosi_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_GAP;
            cnt        <= '0;
            bit_idx    <= '0;
            phase      <= 1'b0;
            target     <= 1'b0;
            shreg      <= '0;
            SCLK       <= 1'b1;
            MOSI       <= 1'b1;
            SS_G       <= 1'b1;
            SS_A       <= 1'b1;
            read_ready <= 1'b0;
            read_data  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            phase      <= phase_n;
            target     <= target_n;
            if (sample)
                shreg <= {shreg[6:0], (target ? MISO_A : MISO_G)};
            SCLK       <= !((state_n == ST_SHIFT) && !phase_n);
            MOSI       <= mosi_n;
            SS_G       <= !(active_n && !target_n);
            SS_A       <= !(active_n && target_n);
            read_ready <= (state_n == ST_DONE);
            if (state_n == ST_DONE)
                read_data <= shreg;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: slave models, bus-rule monitor, scoreboard of returned
// bytes, a response table and hand-built reset / fast-clock sequences.
module tb_spi_master;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n [2];
    logic       rr    [2];
    logic [7:0] rd    [2];
    logic       sclk  [2];
    logic       mosi  [2];
    logic       ssg   [2];
    logic       ssa   [2];
    logic       misog [2];
    logic       misoa [2];
    logic       bit_g [2] = '{1'b1, 1'b1};
    logic       bit_a [2] = '{1'b1, 1'b1};
    logic       noise [2] = '{1'b0, 1'b0};
    logic [7:0] g_resp [2];
    logic [7:0] a_resp [2];

    assign misog[0] = bit_g[0] ^ noise[0];
    assign misoa[0] = bit_a[0] ^ noise[0];
    assign misog[1] = bit_g[1] ^ noise[1];
    assign misoa[1] = bit_a[1] ^ noise[1];

    spi_master dut0 (
        .clk(clk), .reset(rst_n[0]), .read_ready(rr[0]), .read_data(rd[0]),
        .SCLK(sclk[0]), .MOSI(mosi[0]), .MISO_G(misog[0]), .SS_G(ssg[0]),
        .MISO_A(misoa[0]), .SS_A(ssa[0])
    );

    spi_master #(.CLK_DIV(1), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .reset(rst_n[1]), .read_ready(rr[1]), .read_data(rd[1]),
        .SCLK(sclk[1]), .MOSI(mosi[1]), .MISO_G(misog[1]), .SS_G(ssg[1]),
        .MISO_A(misoa[1]), .SS_A(ssa[1])
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- slave models ----------------
    int       nfalls   [2] = '{0, 0};
    int       base     [2] = '{0, 0};
    longint   last_fall[2] = '{0, 0};
    int       per_viol [2] = '{0, 0};
    logic [15:0] sh    [2] = '{16'h0, 16'h0};

    task automatic slave_fall(input int d);
        int   i;
        logic b;
        i = nfalls[d] - base[d];
        nfalls[d]++;
        if (i > 0 && i < 16 && ($time - last_fall[d]) != 20 * ((d == 0) ? 2 : 1))
            per_viol[d]++;
        last_fall[d] = $time;
        if (i >= 8 && i < 16)
            b = (!ssa[d]) ? a_resp[d][15-i] : g_resp[d][15-i];
        else
            b = 1'($urandom_range(1, 0));
        // the deselected slave drives the opposite level to expose a wrong mux
        if (!ssa[d]) begin bit_a[d] = b; bit_g[d] = ~b; end
        else         begin bit_g[d] = b; bit_a[d] = ~b; end
    endtask

    always @(negedge ssg[0] or negedge ssa[0]) base[0] = nfalls[0];
    always @(negedge ssg[1] or negedge ssa[1]) base[1] = nfalls[1];
    always @(negedge sclk[0]) slave_fall(0);
    always @(negedge sclk[1]) slave_fall(1);
    always @(posedge sclk[0]) sh[0] = {sh[0][14:0], mosi[0]};
    always @(posedge sclk[1]) sh[1] = {sh[1][14:0], mosi[1]};

    // ---------------- bus monitor + scoreboard ----------------
    logic [7:0] sbq [2][$];
    logic p_sclk[2] = '{1'b1, 1'b1};
    logic p_mosi[2] = '{1'b1, 1'b1};
    logic p_ssg [2] = '{1'b1, 1'b1};
    logic p_ssa [2] = '{1'b1, 1'b1};
    logic exp_a [2] = '{1'b0, 1'b0};
    int   viol  [2] = '{0, 0};

    task automatic mon(input int d);
        logic win, pwin;
        logic [7:0] e;
        win  = !(ssg[d] && ssa[d]);
        pwin = !(p_ssg[d] && p_ssa[d]);
        if (rst_n[d] !== 1'b1) begin
            sbq[d].delete();
            exp_a[d] = 1'b0;
        end else begin
            if (!ssg[d] && !ssa[d]) viol[d]++;
            if (!win && !pwin && (sclk[d] !== 1'b1 || p_sclk[d] !== 1'b1)) viol[d]++;
            if (win && pwin && mosi[d] !== p_mosi[d] && !(p_sclk[d] === 1'b1 && sclk[d] === 1'b0))
                viol[d]++;
            if (win && !pwin) begin
                chk($sformatf("target%0d", d), !ssa[d], exp_a[d]);
                exp_a[d] = !exp_a[d];
                sbq[d].push_back(!ssa[d] ? a_resp[d] : g_resp[d]);
            end
            if (!win && pwin) begin
                chk($sformatf("edge_rules%0d", d), viol[d], 0);
                chk($sformatf("sclk_low_pulses%0d", d), nfalls[d] - base[d], 16);
                chk($sformatf("cmd%0d", d), sh[d][15:8], !p_ssa[d] ? 8'h80 : 8'h8F);
            end
            if (rr[d] === 1'b1) begin
                if (sbq[d].size() == 0) chk($sformatf("strobe_expected%0d", d), 0, 1);
                else begin
                    e = sbq[d].pop_front();
                    chk($sformatf("read_data%0d", d), rd[d], e);
                end
            end
        end
        p_sclk[d] = sclk[d]; p_mosi[d] = mosi[d];
        p_ssg[d]  = ssg[d];  p_ssa[d]  = ssa[d];
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // ---------------- helpers ----------------
    int hold_viol = 0;

    task automatic wait_strobe(input int d, input int maxc, output int n);
        logic [7:0] prev;
        n = 0;
        prev = rd[d];
        while (n < maxc) begin
            @(posedge clk);
            #1;
            n++;
            if (rr[d] === 1'b1) break;
            if (rd[d] !== prev) hold_viol++;
        end
        chk($sformatf("strobe_seen%0d", d), rr[d], 1'b1);
    endtask

    typedef struct {
        logic [7:0] g_in;
        logic [7:0] a_in;
        logic [7:0] g_exp;
        logic [7:0] a_exp;
    } vec_t;
    vec_t tbl [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, k, rviol;
        tbl[0] = '{8'hD3, 8'hE5, 8'hD3, 8'hE5};
        tbl[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        tbl[2] = '{8'hA5, 8'h5A, 8'hA5, 8'h5A};
        tbl[3] = '{8'h81, 8'h7E, 8'h81, 8'h7E};
        g_resp[0] = 8'hD3; a_resp[0] = 8'hE5;
        g_resp[1] = 8'hA5; a_resp[1] = 8'h3C;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;

        // reset with MISO toggling: every pin must sit at its idle value
        rviol = 0;
        repeat (20) begin
            @(negedge clk);
            noise[0] = !noise[0]; noise[1] = !noise[1];
            #1;
            for (int d = 0; d < 2; d++)
                if (ssg[d] !== 1'b1 || ssa[d] !== 1'b1 || sclk[d] !== 1'b1 ||
                    mosi[d] !== 1'b1 || rr[d] !== 1'b0 || rd[d] !== 8'h00) rviol++;
        end
        noise[0] = 1'b0; noise[1] = 1'b0;
        chk("reset_quiet", rviol, 0);
        chk("reset_ss_g", ssg[0], 1'b1);
        chk("reset_ss_a", ssa[0], 1'b1);
        chk("reset_sclk", sclk[0], 1'b1);
        chk("reset_mosi", mosi[0], 1'b1);
        chk("reset_ready", rr[0], 1'b0);
        chk("reset_data", rd[0], 8'h00);

        // first gyro read lands on clock 73 after release
        @(negedge clk); #1 rst_n[0] = 1'b1;
        wait_strobe(0, 200, n);
        chk("first_strobe_clock", n + 1, 73);
        chk("first_gyro_byte", rd[0], 8'hD3);
        wait_strobe(0, 200, n);
        chk("accel_period", n, 73);
        chk("first_accel_byte", rd[0], 8'hE5);

        for (int i = 0; i < 4; i++) begin
            g_resp[0] = tbl[i].g_in;
            a_resp[0] = tbl[i].a_in;
            wait_strobe(0, 200, n);
            chk($sformatf("tbl%0d_gyro_period", i), n, 73);
            chk($sformatf("tbl%0d_gyro", i), rd[0], tbl[i].g_exp);
            wait_strobe(0, 200, n);
            chk($sformatf("tbl%0d_accel_period", i), n, 73);
            chk($sformatf("tbl%0d_accel", i), rd[0], tbl[i].a_exp);
        end

        // abort an accel transaction during bit 10
        g_resp[0] = 8'hD3; a_resp[0] = 8'hE5;
        k = 0;
        while (ssa[0] !== 1'b0 && k < 400) begin @(negedge clk); k++; end
        chk("accel_window_seen", ssa[0], 1'b0);
        k = 0;
        while ((nfalls[0] - base[0]) < 11 && k < 400) begin @(negedge clk); k++; end
        chk("reached_bit10", nfalls[0] - base[0], 11);
        @(negedge clk);
        #2 rst_n[0] = 1'b0;
        #1;
        chk("abort_ss_g", ssg[0], 1'b1);
        chk("abort_ss_a", ssa[0], 1'b1);
        chk("abort_sclk", sclk[0], 1'b1);
        chk("abort_mosi", mosi[0], 1'b1);
        chk("abort_ready", rr[0], 1'b0);
        chk("abort_data", rd[0], 8'h00);
        repeat (3) @(negedge clk);
        #1 rst_n[0] = 1'b1;
        wait_strobe(0, 200, n);
        chk("post_abort_clock", n + 1, 73);
        chk("post_abort_gyro", rd[0], 8'hD3);

        // fast instance: CLK_DIV=1, GAP_CYCLES=1
        @(negedge clk); #1 rst_n[1] = 1'b1;
        wait_strobe(1, 100, n);
        chk("fast_first_clock", n + 1, 36);
        chk("fast_gyro", rd[1], 8'hA5);
        wait_strobe(1, 100, n);
        chk("fast_period_a", n, 36);
        chk("fast_accel", rd[1], 8'h3C);
        wait_strobe(1, 100, n);
        chk("fast_period_g", n, 36);
        chk("fast_gyro2", rd[1], 8'hA5);

        chk("read_data_hold", hold_viol, 0);
        chk("sclk_period0", per_viol[0], 0);
        chk("sclk_period1", per_viol[1], 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-3 master that polls two slaves on a shared SCLK/MOSI bus: a gyroscope (SS_G/MISO_G) and an accelerometer (SS_A/MISO_A).
- Each transaction sends an 8-bit read command, then clocks in one data byte.
- Transactions alternate gyro, accel, gyro, accel, … and run continuously.
- Each received byte is presented on read_data with a one-cycle read_ready strobe; the block sits between the sensor pins and the attitude-estimation datapath.

Parameters:
- CLK_DIV, 2: system clocks per SCLK half-period (≥1).
- GAP_CYCLES, 4: idle clocks with both SS high between transactions (≥1).
- GYRO_ADDR, 6'h0F: register address read from the gyro.
- ACCEL_ADDR, 6'h00: register address read from the accelerometer.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- read_ready  out  1  one-cycle strobe: read_data updated.
- read_data  out  8  last received byte.
- SCLK  out  1  SPI clock; idles high (CPOL=1).
- MOSI  out  1  master data out, shared by both slaves.
- MISO_G  in  1  gyro data in.
- SS_G  out  1  gyro select, active-low.
- MISO_A  in  1  accel data in.
- SS_A  out  1  accel select, active-low.

Behaviour:
Reset (reset=0, takes effect immediately):
- SS_G=SS_A=1, SCLK=1, MOSI=1, read_ready=0, read_data=8'h00.
- Target=gyro; FSM=GAP with gap counter cleared.
- Reset asserted mid-transaction aborts it with no read_ready; after release, the next transaction is gyro.

Command byte:
- {1'b1 (read), 1'b0 (single byte), addr[5:0]}.
- addr is GYRO_ADDR or ACCEL_ADDR according to target.

FSM states:
- GAP: both SS high, SCLK=1, MOSI=1, for GAP_CYCLES clocks → SETUP.
- SETUP: target SS low; MOSI=cmd[7]; SCLK=1; lasts CLK_DIV clocks → SHIFT, bit index 0.
- SHIFT: 16 bits, index 0..15. Each bit is a low phase (SCLK=0, CLK_DIV clocks) followed by a high phase (SCLK=1, CLK_DIV clocks).
  - MOSI changes only on the clock that drives SCLK 1→0. Bits 0-7 send cmd[7:0] MSB first; bits 8-15 drive MOSI=0.
  - The selected slave's MISO is sampled on the clock that drives SCLK 0→1; the other MISO is ignored.
  - Samples from bits 8-15 shift MSB-first into an 8-bit register. Samples from bits 0-7 are discarded.
  - After bit 15's high phase → HOLD.
- HOLD: SS still low, SCLK=1, for CLK_DIV clocks → DONE.
- DONE (1 clock):
  - SS high, MOSI=1.
  - read_data ← shift register; read_ready=1 for exactly this clock.
  - Target toggles → GAP.

Timing and invariants:
- read_data holds its value between strobes.
- Only one SS is ever low at a time.
- SCLK never toggles while both SS are high.
- Transaction length from SS falling to SS rising: 34·CLK_DIV clocks.
- Period between consecutive read_ready pulses: 34·CLK_DIV + GAP_CYCLES + 1 clocks (73 at defaults).
- First read_ready after reset release: clock 73 at defaults.

Test Plan:
- Reset: hold reset=0 with MISO toggling → SS_G=SS_A=1, SCLK=1, MOSI=1, read_ready=0, read_data=00, no SCLK edges.
- Gyro read: slave model on MISO_G returns 8'hD3 after command → MOSI decodes cmd 8'h8F on SS_G; read_ready pulses once, at clock 73 after reset release; read_data=D3; SS_A stays high throughout.
- Alternation: gyro model returns D3, accel model returns E5 → successive strobes yield D3, E5, D3, E5; accel cmd is 8'h80; strobes are 73 clocks apart.
- Bit-edge check: monitor verifies MOSI stable across every SCLK rising edge, changes only when SCLK falls, and SCLK shows exactly 16 low pulses per SS-low window.
- Mid-transaction reset: pulse reset low during accel bit 10 → outputs return to reset values at once, no strobe; after release the next transaction selects SS_G.
- CLK_DIV=1, GAP_CYCLES=1: gyro slave returns A5 → SCLK period 2 clocks, read_data=A5, strobe period 36 clocks.
